// File: rtl/rob_ptr_recover.sv
// Reorder buffer with wrap-bit head/tail pointers, index-based completion and a multi-cycle
// rollback FSM that squashes younger tags N_WAY per cycle. Define ROB_PERF_CNT_EN for perf counters.
module rob_ptr_recover #(
  parameter int N_ROB    = 32,
  parameter int N_WAY    = 2,
  parameter int N_CDB    = 2,
  parameter int TAG_BITS = 6,
  parameter int XLEN     = 32,
  parameter int ZERO_PR  = 0
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [N_WAY-1:0]                       dis_valid,
  input  logic [N_WAY-1:0][TAG_BITS-1:0]         dis_tag,
  input  logic [N_WAY-1:0][TAG_BITS-1:0]         dis_told,
  input  logic [N_WAY-1:0][XLEN-1:0]             dis_pc,
  input  logic [N_WAY-1:0]                       dis_branch,
  input  logic [N_WAY-1:0]                       dis_store,
  input  logic [N_WAY-1:0]                       dis_halt,
  output logic [$clog2(N_WAY):0]                 dis_free,
  output logic [N_WAY-1:0][$clog2(N_ROB)-1:0]    dis_idx,
  input  logic [N_CDB-1:0]                       cmp_valid,
  input  logic [N_CDB-1:0][$clog2(N_ROB)-1:0]    cmp_idx,
  input  logic [N_CDB-1:0]                       cmp_taken,
  input  logic [N_CDB-1:0][XLEN-1:0]             cmp_target,
  output logic [N_WAY-1:0]                       ret_valid,
  output logic [N_WAY-1:0][TAG_BITS-1:0]         ret_tag,
  output logic [N_WAY-1:0][TAG_BITS-1:0]         ret_free,
  output logic [N_WAY-1:0][XLEN-1:0]             ret_pc,
  output logic [N_WAY-1:0]                       ret_branch,
  output logic [N_WAY-1:0]                       ret_halt,
  output logic [$clog2(N_WAY):0]                 ret_store_cnt,
  output logic                                   flush,
  output logic [XLEN-1:0]                        flush_pc,
  output logic [N_WAY-1:0]                       sq_valid,
  output logic [N_WAY-1:0][TAG_BITS-1:0]         sq_tag,
  output logic                                   busy,
  output logic                                   halted
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]                            perf_retired,
  output logic [31:0]                            perf_flushes,
  output logic [31:0]                            perf_full_cycles,
  output logic [31:0]                            perf_rollback_cycles
`endif
);

  localparam int IW = $clog2(N_ROB);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(N_WAY) + 1;

  typedef enum logic [1:0] {NORMAL, ROLLBACK, HALTED} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]       count, free;
  logic [N_ROB-1:0]    completed_q, completed_d, taken_q, taken_d;
  logic [N_ROB-1:0]    branch_q, branch_d, store_q, store_d, halt_q, halt_d;
  logic [TAG_BITS-1:0] tag_q [N_ROB];
  logic [TAG_BITS-1:0] tag_d [N_ROB];
  logic [TAG_BITS-1:0] told_q [N_ROB];
  logic [TAG_BITS-1:0] told_d [N_ROB];
  logic [XLEN-1:0]     pc_q [N_ROB];
  logic [XLEN-1:0]     pc_d [N_ROB];
  logic [XLEN-1:0]     target_q [N_ROB];
  logic [XLEN-1:0]     target_d [N_ROB];

  logic                stop;
  logic [IW-1:0]       idx, off;
  logic [PW-1:0]       n_ret, n_dis, n_pop;

  assign count  = tail_q - head_q;
  assign free   = PW'(N_ROB) - count;
  assign busy   = (state_q != NORMAL);
  assign halted = (state_q == HALTED);

  always_comb begin
    dis_free = '0;
    if (state_q == NORMAL) begin
      if (free >= PW'(N_WAY)) dis_free = CW'(N_WAY);
      else                    dis_free = CW'(free);
    end
    for (int k = 0; k < N_WAY; k++) dis_idx[k] = tail_q[IW-1:0] + IW'(k);
  end

  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    tail_d        = tail_q;
    completed_d   = completed_q;
    taken_d       = taken_q;
    branch_d      = branch_q;
    store_d       = store_q;
    halt_d        = halt_q;
    tag_d         = tag_q;
    told_d        = told_q;
    pc_d          = pc_q;
    target_d      = target_q;
    ret_valid     = '0;
    ret_tag       = '0;
    ret_free      = '0;
    ret_pc        = '0;
    ret_branch    = '0;
    ret_halt      = '0;
    ret_store_cnt = '0;
    flush         = 1'b0;
    flush_pc      = '0;
    sq_valid      = '0;
    sq_tag        = '0;
    stop          = 1'b0;
    idx           = '0;
    off           = '0;
    n_ret         = '0;
    n_dis         = '0;
    n_pop         = '0;

    if (!reset && state_q == NORMAL) begin
      // Retire looks only at registered completion so a same-cycle completion waits a cycle.
      for (int i = 0; i < N_WAY; i++) begin
        idx = head_q[IW-1:0] + IW'(i);
        if (!stop && PW'(i) < count && completed_q[idx]) begin
          ret_valid[i]  = 1'b1;
          ret_tag[i]    = tag_q[idx];
          ret_free[i]   = (told_q[idx] == TAG_BITS'(ZERO_PR)) ? tag_q[idx] : told_q[idx];
          ret_pc[i]     = pc_q[idx];
          ret_branch[i] = branch_q[idx];
          ret_halt[i]   = halt_q[idx];
          if (store_q[idx]) ret_store_cnt = ret_store_cnt + CW'(1);
          n_ret = n_ret + PW'(1);
          if (branch_q[idx] && taken_q[idx]) begin
            flush    = 1'b1;
            flush_pc = target_q[idx];
            stop     = 1'b1;
            state_d  = ROLLBACK;
          end else if (halt_q[idx]) begin
            stop    = 1'b1;
            state_d = HALTED;
          end
        end else begin
          stop = 1'b1;
        end
      end
      head_d = head_q + n_ret;

      for (int k = 0; k < N_WAY; k++) begin
        if (dis_valid[k] && CW'(k) < dis_free) begin
          idx              = tail_q[IW-1:0] + IW'(k);
          tag_d[idx]       = dis_tag[k];
          told_d[idx]      = dis_told[k];
          pc_d[idx]        = dis_pc[k];
          branch_d[idx]    = dis_branch[k];
          store_d[idx]     = dis_store[k];
          halt_d[idx]      = dis_halt[k];
          completed_d[idx] = dis_halt[k];
          taken_d[idx]     = 1'b0;
          n_dis            = n_dis + PW'(1);
        end
      end
      tail_d = tail_q + n_dis;

      // Later ports overwrite earlier ones, so the highest port wins on a shared index.
      if (!flush) begin
        for (int c = 0; c < N_CDB; c++) begin
          off = cmp_idx[c] - head_q[IW-1:0];
          if (cmp_valid[c] && {1'b0, off} < count) begin
            completed_d[cmp_idx[c]] = 1'b1;
            taken_d[cmp_idx[c]]     = cmp_taken[c];
            target_d[cmp_idx[c]]    = cmp_target[c];
          end
        end
      end
    end else if (!reset && state_q == ROLLBACK) begin
      for (int j = 0; j < N_WAY; j++) begin
        if (PW'(j) < count) begin
          idx              = tail_q[IW-1:0] - IW'(j + 1);
          sq_valid[j]      = 1'b1;
          sq_tag[j]        = tag_q[idx];
          completed_d[idx] = 1'b0;
          n_pop            = n_pop + PW'(1);
        end
      end
      tail_d = tail_q - n_pop;
      if (tail_d == head_q) state_d = NORMAL;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= NORMAL;
      head_q      <= '0;
      tail_q      <= '0;
      completed_q <= '0;
      taken_q     <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      completed_q <= completed_d;
      taken_q     <= taken_d;
    end
  end

  // Payload is only meaningful between head and tail, so it needs no reset.
  always_ff @(posedge clock) begin
    branch_q <= branch_d;
    store_q  <= store_d;
    halt_q   <= halt_d;
    tag_q    <= tag_d;
    told_q   <= told_d;
    pc_q     <= pc_d;
    target_q <= target_d;
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_retired_q, perf_retired_d, perf_flushes_q, perf_flushes_d;
  logic [31:0] perf_full_q, perf_full_d, perf_rb_q, perf_rb_d;
  logic [32:0] ret_sum;

  assign perf_retired         = perf_retired_q;
  assign perf_flushes         = perf_flushes_q;
  assign perf_full_cycles     = perf_full_q;
  assign perf_rollback_cycles = perf_rb_q;

  always_comb begin
    ret_sum        = {1'b0, perf_retired_q} + 33'(n_ret);
    perf_retired_d = ret_sum[32] ? '1 : ret_sum[31:0];
    perf_flushes_d = perf_flushes_q;
    perf_full_d    = perf_full_q;
    perf_rb_d      = perf_rb_q;
    if (flush && perf_flushes_q != '1) perf_flushes_d = perf_flushes_q + 32'd1;
    if (count == PW'(N_ROB) && perf_full_q != '1) perf_full_d = perf_full_q + 32'd1;
    if (state_q == ROLLBACK && perf_rb_q != '1) perf_rb_d = perf_rb_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_retired_q <= '0;
      perf_flushes_q <= '0;
      perf_full_q    <= '0;
      perf_rb_q      <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_flushes_q <= perf_flushes_d;
      perf_full_q    <= perf_full_d;
      perf_rb_q      <= perf_rb_d;
    end
  end
`endif

endmodule

// File: tb/tb_rob_ptr_recover.sv
// Directed self-checking bench for rob_ptr_recover (N_ROB=8, N_WAY=2, N_CDB=2).
module tb_rob_ptr_recover;

  localparam int N_ROB = 8;
  localparam int N_WAY = 2;
  localparam int N_CDB = 2;
  localparam int TAG_BITS = 6;
  localparam int XLEN = 32;

  logic clock;
  logic reset;
  logic [N_WAY-1:0] dis_valid;
  logic [N_WAY-1:0][TAG_BITS-1:0] dis_tag;
  logic [N_WAY-1:0][TAG_BITS-1:0] dis_told;
  logic [N_WAY-1:0][XLEN-1:0] dis_pc;
  logic [N_WAY-1:0] dis_branch, dis_store, dis_halt;
  logic [1:0] dis_free;
  logic [N_WAY-1:0][2:0] dis_idx;
  logic [N_CDB-1:0] cmp_valid;
  logic [N_CDB-1:0][2:0] cmp_idx;
  logic [N_CDB-1:0] cmp_taken;
  logic [N_CDB-1:0][XLEN-1:0] cmp_target;
  logic [N_WAY-1:0] ret_valid;
  logic [N_WAY-1:0][TAG_BITS-1:0] ret_tag, ret_free;
  logic [N_WAY-1:0][XLEN-1:0] ret_pc;
  logic [N_WAY-1:0] ret_branch, ret_halt;
  logic [1:0] ret_store_cnt;
  logic flush;
  logic [XLEN-1:0] flush_pc;
  logic [N_WAY-1:0] sq_valid;
  logic [N_WAY-1:0][TAG_BITS-1:0] sq_tag;
  logic busy;
  logic halted;

  int vectors = 0;
  int miscompares = 0;

  rob_ptr_recover #(
    .N_ROB(N_ROB), .N_WAY(N_WAY), .N_CDB(N_CDB),
    .TAG_BITS(TAG_BITS), .XLEN(XLEN), .ZERO_PR(0)
  ) dut (
    .clock(clock), .reset(reset),
    .dis_valid(dis_valid), .dis_tag(dis_tag), .dis_told(dis_told), .dis_pc(dis_pc),
    .dis_branch(dis_branch), .dis_store(dis_store), .dis_halt(dis_halt),
    .dis_free(dis_free), .dis_idx(dis_idx),
    .cmp_valid(cmp_valid), .cmp_idx(cmp_idx), .cmp_taken(cmp_taken), .cmp_target(cmp_target),
    .ret_valid(ret_valid), .ret_tag(ret_tag), .ret_free(ret_free), .ret_pc(ret_pc),
    .ret_branch(ret_branch), .ret_halt(ret_halt), .ret_store_cnt(ret_store_cnt),
    .flush(flush), .flush_pc(flush_pc), .sq_valid(sq_valid), .sq_tag(sq_tag),
    .busy(busy), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [TAG_BITS-1:0] tag_of(input int s);
    return TAG_BITS'(s + 1);
  endfunction

  function automatic logic [TAG_BITS-1:0] told_of(input int s);
    return (s % 2 == 1) ? TAG_BITS'(s + 20) : TAG_BITS'(0);
  endfunction

  function automatic logic [XLEN-1:0] pc_of(input int s);
    return XLEN'(32'h100 + 4 * s);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    dis_valid  = '0;
    dis_tag    = '0;
    dis_told   = '0;
    dis_pc     = '0;
    dis_branch = '0;
    dis_store  = '0;
    dis_halt   = '0;
    cmp_valid  = '0;
    cmp_idx    = '0;
    cmp_taken  = '0;
    cmp_target = '0;
  endtask

  // Drive `lanes` dispatch lanes carrying sequence numbers s, s+1.
  task automatic applyStimulus(input int lanes, input int s, input logic [1:0] br,
                               input logic [1:0] st, input logic [1:0] ht);
    for (int k = 0; k < N_WAY; k++) begin
      dis_valid[k]  = (k < lanes);
      dis_tag[k]    = tag_of(s + k);
      dis_told[k]   = told_of(s + k);
      dis_pc[k]     = pc_of(s + k);
      dis_branch[k] = br[k];
      dis_store[k]  = st[k];
      dis_halt[k]   = ht[k];
    end
  endtask

  task automatic setCompletion(input int port, input int idx, input logic tk,
                               input logic [XLEN-1:0] tgt);
    cmp_valid[port]  = 1'b1;
    cmp_idx[port]    = 3'(idx);
    cmp_taken[port]  = tk;
    cmp_target[port] = tgt;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
    $display("[TB] reset state");
    checkOutput("rst_dis_free", 64'(dis_free), 64'd2);
    checkOutput("rst_dis_idx0", 64'(dis_idx[0]), 64'd0);
    checkOutput("rst_dis_idx1", 64'(dis_idx[1]), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_halted", 64'(halted), 64'd0);
    checkOutput("rst_ret_valid", 64'(ret_valid), 64'd0);
    checkOutput("rst_sq_valid", 64'(sq_valid), 64'd0);
    checkOutput("rst_flush", 64'(flush), 64'd0);

    $display("[TB] fill to full, entry 6 is a branch, entry 1 a store");
    for (int c = 0; c < 4; c++) begin
      idle();
      applyStimulus(2, 2 * c, (c == 3) ? 2'b01 : 2'b00, (c == 0) ? 2'b10 : 2'b00, 2'b00);
      settle();
      checkOutput("fill_dis_idx0", 64'(dis_idx[0]), 64'(2 * c));
      checkOutput("fill_dis_idx1", 64'(dis_idx[1]), 64'(2 * c + 1));
      checkOutput("fill_dis_free", 64'(dis_free), 64'd2);
      tick();
    end
    idle();
    applyStimulus(2, 8, 2'b00, 2'b00, 2'b00);
    settle();
    checkOutput("full_dis_free", 64'(dis_free), 64'd0);
    tick();
    idle();
    settle();
    checkOutput("full_hold_dis_free", 64'(dis_free), 64'd0);
    checkOutput("full_no_retire", 64'(ret_valid), 64'd0);

    $display("[TB] complete idx 1 then idx 0");
    setCompletion(0, 1, 1'b0, '0);
    settle();
    checkOutput("cmp1_same_cycle", 64'(ret_valid), 64'd0);
    tick();
    idle();
    settle();
    checkOutput("only_idx1_done", 64'(ret_valid), 64'd0);
    setCompletion(0, 0, 1'b0, '0);
    settle();
    checkOutput("cmp0_same_cycle", 64'(ret_valid), 64'd0);
    tick();
    idle();
    settle();
    checkOutput("ret01_valid", 64'(ret_valid), 64'b11);
    checkOutput("ret01_pc0", 64'(ret_pc[0]), 64'(pc_of(0)));
    checkOutput("ret01_pc1", 64'(ret_pc[1]), 64'(pc_of(1)));
    checkOutput("ret01_tag0", 64'(ret_tag[0]), 64'(tag_of(0)));
    checkOutput("ret01_free0", 64'(ret_free[0]), 64'(tag_of(0)));
    checkOutput("ret01_free1", 64'(ret_free[1]), 64'(told_of(1)));
    checkOutput("ret01_stores", 64'(ret_store_cnt), 64'd1);
    checkOutput("ret01_dis_free", 64'(dis_free), 64'd0);
    tick();
    idle();
    settle();
    checkOutput("after_ret_dis_free", 64'(dis_free), 64'd2);

    $display("[TB] drain to head=6, then taken branch at 6");
    setCompletion(0, 2, 1'b0, '0);
    setCompletion(1, 3, 1'b0, '0);
    tick();
    idle();
    settle();
    checkOutput("ret23_valid", 64'(ret_valid), 64'b11);
    checkOutput("ret23_pc0", 64'(ret_pc[0]), 64'(pc_of(2)));
    setCompletion(0, 4, 1'b0, '0);
    setCompletion(1, 5, 1'b0, '0);
    tick();
    idle();
    settle();
    checkOutput("ret45_valid", 64'(ret_valid), 64'b11);
    checkOutput("ret45_pc1", 64'(ret_pc[1]), 64'(pc_of(5)));
    tick();
    idle();
    applyStimulus(2, 8, 2'b00, 2'b00, 2'b00);
    setCompletion(0, 6, 1'b1, 32'h400);
    settle();
    checkOutput("wrap_dis_idx0", 64'(dis_idx[0]), 64'd0);
    checkOutput("wrap_dis_idx1", 64'(dis_idx[1]), 64'd1);
    tick();
    idle();
    settle();
    checkOutput("br_flush", 64'(flush), 64'd1);
    checkOutput("br_flush_pc", 64'(flush_pc), 64'h400);
    checkOutput("br_ret_valid", 64'(ret_valid), 64'b01);
    checkOutput("br_ret_branch", 64'(ret_branch), 64'b01);
    checkOutput("br_ret_pc", 64'(ret_pc[0]), 64'(pc_of(6)));
    tick();
    idle();
    settle();
    checkOutput("rb1_busy", 64'(busy), 64'd1);
    checkOutput("rb1_dis_free", 64'(dis_free), 64'd0);
    checkOutput("rb1_flush", 64'(flush), 64'd0);
    checkOutput("rb1_sq_valid", 64'(sq_valid), 64'b11);
    checkOutput("rb1_sq_tag0", 64'(sq_tag[0]), 64'(tag_of(9)));
    checkOutput("rb1_sq_tag1", 64'(sq_tag[1]), 64'(tag_of(8)));
    tick();
    idle();
    settle();
    checkOutput("rb2_sq_valid", 64'(sq_valid), 64'b01);
    checkOutput("rb2_sq_tag0", 64'(sq_tag[0]), 64'(tag_of(7)));
    tick();
    idle();
    settle();
    checkOutput("rb_done_busy", 64'(busy), 64'd0);
    checkOutput("rb_done_dis_free", 64'(dis_free), 64'd2);
    checkOutput("rb_done_sq_valid", 64'(sq_valid), 64'd0);
    checkOutput("rb_done_dis_idx0", 64'(dis_idx[0]), 64'd7);

    $display("[TB] streaming 20 entries across the wrap");
    for (int c = 0; c < 12; c++) begin
      idle();
      if (c < 10) begin
        applyStimulus(2, 10 + 2 * c, 2'b00, 2'b00, 2'b00);
      end
      if (c >= 1 && c <= 10) begin
        setCompletion(0, (7 + 2 * (c - 1)) % 8, 1'b0, '0);
        setCompletion(1, (8 + 2 * (c - 1)) % 8, 1'b0, '0);
      end
      settle();
      if (c < 10) begin
        checkOutput("str_dis_idx0", 64'(dis_idx[0]), 64'((7 + 2 * c) % 8));
        checkOutput("str_dis_free", 64'(dis_free), 64'd2);
      end
      if (c >= 2) begin
        checkOutput("str_ret_valid", 64'(ret_valid), 64'b11);
        checkOutput("str_ret_pc0", 64'(ret_pc[0]), 64'(pc_of(10 + 2 * (c - 2))));
        checkOutput("str_ret_pc1", 64'(ret_pc[1]), 64'(pc_of(11 + 2 * (c - 2))));
      end else begin
        checkOutput("str_ret_idle", 64'(ret_valid), 64'd0);
      end
      tick();
    end
    idle();
    settle();
    checkOutput("empty_w1_ret", 64'(ret_valid), 64'd0);
    checkOutput("empty_w1_dis_free", 64'(dis_free), 64'd2);
    checkOutput("empty_w1_dis_idx0", 64'(dis_idx[0]), 64'd3);

    $display("[TB] out-of-range completion and completion/retire collision");
    applyStimulus(1, 30, 2'b00, 2'b00, 2'b00);
    setCompletion(0, 3, 1'b0, '0);
    setCompletion(1, 5, 1'b0, '0);
    tick();
    idle();
    settle();
    checkOutput("oor_no_retire", 64'(ret_valid), 64'd0);
    setCompletion(0, 3, 1'b0, '0);
    settle();
    checkOutput("collide_same_cycle", 64'(ret_valid), 64'd0);
    tick();
    idle();
    settle();
    checkOutput("collide_ret_valid", 64'(ret_valid), 64'b01);
    checkOutput("collide_ret_pc", 64'(ret_pc[0]), 64'(pc_of(30)));
    tick();

    $display("[TB] halt in lane 1 behind incomplete store in lane 0");
    for (int c = 0; c < 4; c++) begin
      idle();
      applyStimulus(2, 31 + 2 * c, 2'b00, (c == 0) ? 2'b01 : 2'b00, (c == 0) ? 2'b10 : 2'b00);
      settle();
      checkOutput("hfill_dis_idx0", 64'(dis_idx[0]), 64'((4 + 2 * c) % 8));
      tick();
    end
    idle();
    settle();
    checkOutput("full_w_dis_free", 64'(dis_free), 64'd0);
    checkOutput("halt_wait", 64'(ret_valid), 64'd0);
    setCompletion(0, 4, 1'b0, '0);
    tick();
    idle();
    settle();
    checkOutput("halt_ret_valid", 64'(ret_valid), 64'b11);
    checkOutput("halt_ret_halt", 64'(ret_halt), 64'b10);
    checkOutput("halt_ret_pc1", 64'(ret_pc[1]), 64'(pc_of(32)));
    checkOutput("halt_stores", 64'(ret_store_cnt), 64'd1);
    checkOutput("halt_not_yet", 64'(halted), 64'd0);
    tick();
    idle();
    settle();
    checkOutput("halted_set", 64'(halted), 64'd1);
    checkOutput("halted_busy", 64'(busy), 64'd1);
    checkOutput("halted_ret", 64'(ret_valid), 64'd0);
    applyStimulus(2, 40, 2'b00, 2'b00, 2'b00);
    setCompletion(0, 6, 1'b0, '0);
    settle();
    checkOutput("halted_dis_free", 64'(dis_free), 64'd0);
    tick();
    idle();
    settle();
    checkOutput("halted_dis_idx0", 64'(dis_idx[0]), 64'd4);
    checkOutput("halted_no_retire", 64'(ret_valid), 64'd0);
    checkOutput("halted_sq", 64'(sq_valid), 64'd0);
    checkOutput("halted_hold", 64'(halted), 64'd1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    checkOutput("rst2_halted", 64'(halted), 64'd0);
    checkOutput("rst2_busy", 64'(busy), 64'd0);
    checkOutput("rst2_dis_free", 64'(dis_free), 64'd2);
    checkOutput("rst2_dis_idx0", 64'(dis_idx[0]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
